// File: rtl/rr_register_file_if.sv
// Write-arbitration and read bus of the round-robin register file.
// Latency: none; this is only a bundle of wires.
// Backpressure: a requester that is not granted holds wr_req/addr/data until it is granted.
interface rr_register_file_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int NUM_WP = 2
);
  logic [NUM_WP-1:0]        wr_req;
  logic [NUM_WP*ADDR_W-1:0] wr_addr;
  logic [NUM_WP*WIDTH-1:0]  wr_data;
  logic [NUM_WP-1:0]        wr_grant;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [WIDTH-1:0]         rd_data;
  logic                     rd_valid;
  logic                     clr;

  // Producers and the read consumer drive requests and observe grant and read data.
  modport master (
    output wr_req, wr_addr, wr_data, rd_en, rd_addr, clr,
    input  wr_grant, rd_data, rd_valid
  );

  // The register file consumes requests and returns grant and read data.
  modport slave (
    input  wr_req, wr_addr, wr_data, rd_en, rd_addr, clr,
    output wr_grant, rd_data, rd_valid
  );
endinterface

// File: rtl/rr_register_file.sv
// Multi-port register file: NUM_WP writers share one write slot per cycle via round-robin grant.
// Latency: write commits at the granting edge; read data/valid registered one edge after rd_en.
// Backpressure: losing writers see wr_grant=0 and must hold their request; nothing is queued.
module rr_register_file #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int NUM_WP = 2
) (
  input logic              clk,
  input logic              reset,
  rr_register_file_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = (NUM_WP > 1) ? $clog2(NUM_WP) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rd_data_q;
  logic              rd_valid_q;

  logic [NUM_WP-1:0] grant;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W:0]    cand;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;

  // Search ports ptr, ptr+1, ... (mod NUM_WP); the first requester wins the slot.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_WP; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W + 1)'(i);
      if (cand >= (PTR_W + 1)'(NUM_WP)) begin
        cand = cand - (PTR_W + 1)'(NUM_WP);
      end
      if (!grant_any && bus.wr_req[cand[PTR_W-1:0]]) begin
        grant[cand[PTR_W-1:0]] = 1'b1;
        grant_idx              = cand[PTR_W-1:0];
        grant_any              = 1'b1;
      end
    end
  end

  // Route the granted port's address and data to the storage write port.
  always_comb begin
    waddr = '0;
    wdata = '0;
    for (int p = 0; p < NUM_WP; p++) begin
      if (grant[p]) begin
        waddr = bus.wr_addr[p*ADDR_W +: ADDR_W];
        wdata = bus.wr_data[p*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer moves past the winner; clear rewinds it; no grant leaves it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (bus.clr) begin
      ptr_d = '0;
    end else if (grant_any) begin
      ptr_d = (grant_idx == PTR_W'(NUM_WP - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage array: clear wins over the granted write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else if (bus.clr) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else if (grant_any) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read of pre-edge contents; data holds when no read is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q <= mem_q[bus.rd_addr];
      end
    end
  end

  // Grant is suppressed while reset is held low.
  assign bus.wr_grant = reset ? grant : '0;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_rr_register_file.sv
// Bench for rr_register_file: two-port and three-port instances.
// Read results are checked against a model through an expected-value queue.
// Write grants are checked against a vector table and hand-written sequences.
module tb_rr_register_file;
  localparam int W  = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_register_file_if #(.WIDTH(W), .ADDR_W(AW), .NUM_WP(2)) bus2 ();
  rr_register_file_if #(.WIDTH(W), .ADDR_W(AW), .NUM_WP(3)) bus3 ();

  rr_register_file #(.WIDTH(W), .ADDR_W(AW), .NUM_WP(2)) u_dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  rr_register_file #(.WIDTH(W), .ADDR_W(AW), .NUM_WP(3)) u_dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus3)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] mem_m [8];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] mon_e;

  typedef struct {
    logic [1:0]  req;
    logic [2:0]  a0;
    logic [2:0]  a1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  g;
  } wvec_t;
  wvec_t vt [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pop one expected value for every read result the two-port instance presents.
  always @(negedge clk) begin
    if (bus2.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_data", bus2.rd_data, mon_e);
      end
    end
  end

  task automatic idle2();
    bus2.wr_req = '0; bus2.wr_addr = '0; bus2.wr_data = '0;
    bus2.rd_en = 1'b0; bus2.rd_addr = '0; bus2.clr = 1'b0;
  endtask

  task automatic idle3();
    bus3.wr_req = '0; bus3.wr_addr = '0; bus3.wr_data = '0;
    bus3.rd_en = 1'b0; bus3.rd_addr = '0; bus3.clr = 1'b0;
  endtask

  // One cycle on the two-port instance; model is updated with the expected grant.
  task automatic cyc2(input string name, input logic [1:0] req, input logic [2:0] a0,
                      input logic [2:0] a1, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [1:0] g, input logic ren, input logic [2:0] ra,
                      input logic clr);
    bus2.wr_req = req; bus2.wr_addr = {a1, a0}; bus2.wr_data = {d1, d0};
    bus2.rd_en = ren; bus2.rd_addr = ra; bus2.clr = clr;
    #1;
    check(name, bus2.wr_grant, g);
    if (ren) exp_q.push_back(mem_m[ra]);
    if (clr) begin
      for (int e = 0; e < 8; e++) mem_m[e] = '0;
    end else if (g[0]) begin
      mem_m[a0] = d0;
    end else if (g[1]) begin
      mem_m[a1] = d1;
    end
    @(posedge clk); #1;
    idle2();
  endtask

  task automatic rd2(input logic [2:0] ra);
    cyc2("rd_idle_grant", 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 2'b00, 1'b1, ra, 1'b0);
  endtask

  task automatic cyc3(input string name, input logic [2:0] req, input logic [8:0] addrs,
                      input logic [47:0] datas, input logic [2:0] g);
    bus3.wr_req = req; bus3.wr_addr = addrs; bus3.wr_data = datas;
    #1;
    check(name, bus3.wr_grant, g);
    @(posedge clk); #1;
    idle3();
  endtask

  initial begin
    vt[0] = '{2'b11, 3'd1, 3'd2, 16'h1111, 16'h2222, 2'b01};
    vt[1] = '{2'b11, 3'd1, 3'd2, 16'h1111, 16'h2222, 2'b10};
    vt[2] = '{2'b11, 3'd1, 3'd2, 16'h1111, 16'h2222, 2'b01};
    vt[3] = '{2'b11, 3'd1, 3'd2, 16'h1111, 16'h2222, 2'b10};
    vt[4] = '{2'b10, 3'd0, 3'd6, 16'h0000, 16'h6666, 2'b10};
    vt[5] = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 2'b00};
    vt[6] = '{2'b01, 3'd7, 3'd0, 16'h7777, 16'h0000, 2'b01};
    vt[7] = '{2'b01, 3'd5, 3'd0, 16'h00AA, 16'h0000, 2'b01};
    vt[8] = '{2'b11, 3'd0, 3'd0, 16'h0BAD, 16'h0C0D, 2'b10};
    for (int e = 0; e < 8; e++) mem_m[e] = '0;

    // Reset state, including grant suppression while reset is low.
    reset = 1'b0;
    idle2();
    idle3();
    #12;
    check("reset_rd_data", bus2.rd_data, 16'h0);
    check("reset_rd_valid", bus2.rd_valid, 1'b0);
    bus2.wr_req = 2'b11;
    bus3.wr_req = 3'b111;
    #1;
    check("reset_grant2", bus2.wr_grant, 2'b00);
    check("reset_grant3", bus3.wr_grant, 3'b000);
    idle2();
    idle3();
    @(posedge clk); #1;
    reset = 1'b1;

    // Round-robin and single-requester vectors.
    for (int i = 0; i < 9; i++) begin
      cyc2($sformatf("vec%0d_grant", i), vt[i].req, vt[i].a0, vt[i].a1,
           vt[i].d0, vt[i].d1, vt[i].g, 1'b0, 3'd0, 1'b0);
    end
    rd2(3'd1); rd2(3'd2); rd2(3'd6); rd2(3'd7); rd2(3'd5); rd2(3'd0); rd2(3'd3);

    // Read and write of the same address in one cycle returns the old value.
    cyc2("rdw_grant", 2'b01, 3'd5, 3'd0, 16'h0055, 16'h0, 2'b01, 1'b1, 3'd5, 1'b0);
    rd2(3'd5);

    // Idle: valid drops, data holds.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("idle%0d_valid", k), bus2.rd_valid, 1'b0);
      check($sformatf("idle%0d_data", k), bus2.rd_data, 16'h0055);
    end

    // Clear: fill, leave ptr at 1, clear with a competing write shown as granted.
    for (int e = 0; e < 8; e++) begin
      cyc2("fill_grant", 2'b10, 3'd0, 3'(e), 16'h0, 16'hFFFF, 2'b10, 1'b0, 3'd0, 1'b0);
    end
    cyc2("fill0_grant", 2'b01, 3'd0, 3'd0, 16'hFFFF, 16'h0, 2'b01, 1'b0, 3'd0, 1'b0);
    cyc2("clr_grant", 2'b01, 3'd0, 3'd0, 16'h1234, 16'h0, 2'b01, 1'b1, 3'd0, 1'b1);
    for (int e = 0; e < 8; e++) rd2(3'(e));
    cyc2("clr_ptr_grant", 2'b11, 3'd3, 3'd4, 16'h3333, 16'h4444, 2'b01, 1'b0, 3'd0, 1'b0);

    // Reset asserted between edges while a read result is shown and a write is pending.
    cyc2("beef_grant", 2'b01, 3'd3, 3'd0, 16'hBEEF, 16'h0, 2'b01, 1'b0, 3'd0, 1'b0);
    bus2.rd_en = 1'b1; bus2.rd_addr = 3'd3;
    @(posedge clk); #1;
    check("beef_rd_valid", bus2.rd_valid, 1'b1);
    check("beef_rd_data", bus2.rd_data, 16'hBEEF);
    bus2.rd_en = 1'b0;
    bus2.wr_req = 2'b01; bus2.wr_addr = {3'd0, 3'd4}; bus2.wr_data = {16'h0, 16'h7777};
    #1 reset = 1'b0;
    #1;
    check("midrst_rd_data", bus2.rd_data, 16'h0);
    check("midrst_rd_valid", bus2.rd_valid, 1'b0);
    check("midrst_grant", bus2.wr_grant, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;
    idle2();
    for (int e = 0; e < 8; e++) mem_m[e] = '0;
    rd2(3'd3);
    rd2(3'd4);
    cyc2("rst_ptr_grant", 2'b11, 3'd1, 3'd2, 16'h1, 16'h2, 2'b01, 1'b0, 3'd0, 1'b0);

    // Three ports: contention with ptr=1, then full rotation.
    cyc3("p3_set_ptr", 3'b001, {3'd0, 3'd0, 3'd0}, {16'h0, 16'h0, 16'h0A0A}, 3'b001);
    cyc3("p3_cont0", 3'b101, {3'd6, 3'd0, 3'd1}, {16'h2AAA, 16'h0, 16'h1010}, 3'b100);
    cyc3("p3_cont1", 3'b101, {3'd6, 3'd0, 3'd1}, {16'h2AAA, 16'h0, 16'h1010}, 3'b001);
    cyc3("p3_cont2", 3'b101, {3'd6, 3'd0, 3'd1}, {16'h2AAA, 16'h0, 16'h1010}, 3'b100);
    cyc3("p3_rot0", 3'b111, {3'd4, 3'd3, 3'd2}, {16'h4444, 16'h3333, 16'h2222}, 3'b001);
    cyc3("p3_rot1", 3'b111, {3'd4, 3'd3, 3'd2}, {16'h4444, 16'h3333, 16'h2222}, 3'b010);
    cyc3("p3_rot2", 3'b111, {3'd4, 3'd3, 3'd2}, {16'h4444, 16'h3333, 16'h2222}, 3'b100);
    bus3.rd_en = 1'b1; bus3.rd_addr = 3'd6;
    @(posedge clk); #1;
    check("p3_rd6", bus3.rd_data, 16'h2AAA);
    bus3.rd_addr = 3'd1;
    @(posedge clk); #1;
    check("p3_rd1", bus3.rd_data, 16'h1010);
    bus3.rd_addr = 3'd3;
    @(posedge clk); #1;
    check("p3_rd3", bus3.rd_data, 16'h3333);
    check("p3_rd_valid", bus3.rd_valid, 1'b1);
    idle3();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
